// File: rtl/dds_communication_if.sv
`default_nettype none
// ============================================================================
// Module   : dds_communication_if
// Brief    : UART byte link and DDS control bundle for the command decoder.
// Revision : 1.0
// ============================================================================
interface dds_communication_if;
    logic        received;
    logic [7:0]  rx_byte;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        en;
    logic [39:0] m;
    logic        set;
    logic        error;

    modport slave (
        input  received, rx_byte,
        output transmit, tx_byte, en, m, set, error
    );

    modport master (
        output received, rx_byte,
        input  transmit, tx_byte, en, m, set, error
    );
endinterface
`default_nettype wire

// File: rtl/dds_communication.sv
`default_nettype none
// ============================================================================
// Module   : dds_communication
// Brief    : UART command decoder building and committing the DDS tuning word.
// Revision : 1.0
// ============================================================================
module dds_communication (
    input  wire logic           clk,
    input  wire logic           rst,
    dds_communication_if.slave  dds_io
);

    localparam logic [7:0] BYTE0       = 8'h01;
    localparam logic [7:0] BYTE1       = 8'h02;
    localparam logic [7:0] BYTE2       = 8'h03;
    localparam logic [7:0] BYTE3       = 8'h04;
    localparam logic [7:0] BYTE4       = 8'h05;
    localparam logic [7:0] CMD_SET     = 8'h06;
    localparam logic [7:0] CMD_ENABLE  = 8'h07;
    localparam logic [7:0] CMD_DISABLE = 8'h08;
    localparam logic [7:0] ACK_ERR     = 8'hFF;

    typedef enum logic [0:0] {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t      state_q;
    logic        rx_prev_q;
    logic [2:0]  idx_q;
    logic [39:0] shadow_q;
    logic [39:0] m_q;
    logic        en_q;
    logic        set_q;
    logic        transmit_q;
    logic [7:0]  tx_byte_q;
    logic        error_q;
    logic        rx_rise;

    // A strobe held high for several cycles is a single byte.
    assign rx_rise = dds_io.received & ~rx_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CMD;
            rx_prev_q  <= 1'b0;
            idx_q      <= 3'd0;
            shadow_q   <= 40'd0;
            m_q        <= 40'd0;
            en_q       <= 1'b0;
            set_q      <= 1'b0;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            rx_prev_q  <= dds_io.received;
            set_q      <= 1'b0;
            transmit_q <= 1'b0;
            if (rx_rise) begin
                if (state_q == ST_CMD) begin
                    case (dds_io.rx_byte)
                        BYTE0, BYTE1, BYTE2, BYTE3, BYTE4: begin
                            idx_q   <= dds_io.rx_byte[2:0] - 3'd1;
                            state_q <= ST_DATA;
                        end
                        CMD_SET: begin
                            m_q        <= shadow_q;
                            set_q      <= 1'b1;
                            transmit_q <= 1'b1;
                            tx_byte_q  <= dds_io.rx_byte;
                            error_q    <= 1'b0;
                        end
                        CMD_ENABLE, CMD_DISABLE: begin
                            en_q       <= (dds_io.rx_byte == CMD_ENABLE);
                            transmit_q <= 1'b1;
                            tx_byte_q  <= dds_io.rx_byte;
                            error_q    <= 1'b0;
                        end
                        default: begin
                            error_q    <= 1'b1;
                            transmit_q <= 1'b1;
                            tx_byte_q  <= ACK_ERR;
                        end
                    endcase
                end else begin
                    // Data byte: taken verbatim, even if it looks like a command.
                    shadow_q[{idx_q, 3'b000} +: 8] <= dds_io.rx_byte;
                    transmit_q <= 1'b1;
                    tx_byte_q  <= {5'd0, idx_q} + 8'd1;
                    error_q    <= 1'b0;
                    state_q    <= ST_CMD;
                end
            end
        end
    end

    assign dds_io.transmit = transmit_q;
    assign dds_io.tx_byte  = tx_byte_q;
    assign dds_io.en       = en_q;
    assign dds_io.m        = m_q;
    assign dds_io.set      = set_q;
    assign dds_io.error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_communication.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_communication
// Brief    : Scoreboard bench for the DDS command decoder.
// Revision : 1.0
// ============================================================================
module tb_dds_communication;

    typedef struct packed {
        logic [7:0]  tx;
        logic        set;
        logic [39:0] m;
        logic        en;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    exp_t exp_q[$];

    dds_communication_if dut_if ();

    dds_communication u_dut (
        .clk    (clk),
        .rst    (rst),
        .dds_io (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endfunction

    function automatic void expect_ack(logic [7:0] tx, logic s, logic [39:0] m,
                                       logic en, logic err);
        exp_t e;
        e.tx = tx; e.set = s; e.m = m; e.en = en; e.err = err;
        exp_q.push_back(e);
    endfunction

    // Caller sits at a negedge; returns at a negedge after the strobe dropped.
    task automatic send(input logic [7:0] b, input int hold);
        dut_if.received = 1'b1;
        dut_if.rx_byte  = b;
        repeat (hold) @(negedge clk);
        dut_if.received = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_transmit"}, {63'd0, dut_if.transmit}, 64'd0);
        check({tag, "_tx_byte"},  {56'd0, dut_if.tx_byte},  64'd0);
        check({tag, "_en"},       {63'd0, dut_if.en},       64'd0);
        check({tag, "_m"},        {24'd0, dut_if.m},        64'd0);
        check({tag, "_set"},      {63'd0, dut_if.set},      64'd0);
        check({tag, "_error"},    {63'd0, dut_if.error},    64'd0);
    endtask

    // Monitor: every transmit pulse must match the oldest expected ack.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_if.transmit) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {56'd0, dut_if.tx_byte}, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_tx_byte", {56'd0, dut_if.tx_byte}, {56'd0, e.tx});
                    check("ack_set",     {63'd0, dut_if.set},     {63'd0, e.set});
                    check("ack_m",       {24'd0, dut_if.m},       {24'd0, e.m});
                    check("ack_en",      {63'd0, dut_if.en},      {63'd0, e.en});
                    check("ack_error",   {63'd0, dut_if.error},   {63'd0, e.err});
                end
            end else if (dut_if.set) begin
                check("set_without_ack", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    localparam logic [39:0] M_FULL = 40'h0002672A22;
    localparam logic [39:0] M_MOD  = 40'h0002670622;

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        dut_if.received = 1'b0;
        dut_if.rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full word load: m must hold 0 until SET.
        send(8'h01, 1); expect_ack(8'h01, 1'b0, 40'd0, 1'b0, 1'b0); send(8'h22, 1);
        send(8'h02, 1); expect_ack(8'h02, 1'b0, 40'd0, 1'b0, 1'b0); send(8'h2A, 1);
        send(8'h03, 1); expect_ack(8'h03, 1'b0, 40'd0, 1'b0, 1'b0); send(8'h67, 1);
        send(8'h04, 1); expect_ack(8'h04, 1'b0, 40'd0, 1'b0, 1'b0); send(8'h02, 1);
        send(8'h05, 1); expect_ack(8'h05, 1'b0, 40'd0, 1'b0, 1'b0); send(8'h00, 1);
        check("m_before_set", {24'd0, dut_if.m}, 64'd0);
        expect_ack(8'h06, 1'b1, M_FULL, 1'b0, 1'b0); send(8'h06, 1);
        check("m_after_set", {24'd0, dut_if.m}, {24'd0, M_FULL});
        check("m_decimal", {24'd0, dut_if.m}, 64'd40315426);

        // Enable / disable / unknown commands.
        expect_ack(8'h07, 1'b0, M_FULL, 1'b1, 1'b0); send(8'h07, 1);
        expect_ack(8'h08, 1'b0, M_FULL, 1'b0, 1'b0); send(8'h08, 1);
        expect_ack(8'h07, 1'b0, M_FULL, 1'b1, 1'b0); send(8'h07, 1);
        expect_ack(8'hFF, 1'b0, M_FULL, 1'b1, 1'b1); send(8'h00, 1);
        check("error_level", {63'd0, dut_if.error}, 64'd1);
        expect_ack(8'h07, 1'b0, M_FULL, 1'b1, 1'b0); send(8'h07, 1);
        expect_ack(8'hFF, 1'b0, M_FULL, 1'b1, 1'b1); send(8'hAB, 1);
        expect_ack(8'h08, 1'b0, M_FULL, 1'b0, 1'b0); send(8'h08, 1);

        // Data byte equal to SET is stored, not executed.
        send(8'h02, 1);
        expect_ack(8'h02, 1'b0, M_FULL, 1'b0, 1'b0); send(8'h06, 1);
        // Long strobe commits the modified shadow exactly once.
        expect_ack(8'h06, 1'b1, M_MOD, 1'b0, 1'b0); send(8'h06, 5);
        repeat (3) @(negedge clk);
        check("m_after_long_set", {24'd0, dut_if.m}, {24'd0, M_MOD});

        // Reset mid-command discards the pending BYTE2 index.
        send(8'h03, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        expect_ack(8'hFF, 1'b0, 40'd0, 1'b0, 1'b1); send(8'h55, 1);

        // Strobe already high when reset releases counts as a new byte.
        rst = 1'b1;
        dut_if.received = 1'b1;
        dut_if.rx_byte  = 8'h07;
        repeat (2) @(negedge clk);
        expect_ack(8'h07, 1'b0, 40'd0, 1'b1, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        dut_if.received = 1'b0;
        @(negedge clk);

        repeat (5) @(negedge clk);
        check("pending_acks", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
